// File: rtl/dcache_access_sequencer.sv
// MEM-stage data cache sequencer: one outstanding load/store,
// registered cache handshake, byte lanes, and a hung-cache timeout.
module dcache_access_sequencer #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_valid,
   input  logic              d_cache_access,
   input  logic              d_cache_op,
   input  logic              is_byte_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   input  logic              flush,
   output logic              cache_req,
   output logic              cache_op,
   output logic              cache_byte,
   output logic [ADDR_W-1:0] cache_addr,
   output logic [31:0]       cache_wdata,
   input  logic              cache_ready,
   input  logic [31:0]       cache_rdata,
   output logic              stall,
   output logic              load_valid,
   output logic [31:0]       load_data,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             discard;
   logic             accept;
   logic             hit_timeout;
   logic [7:0]       rbyte;
   logic [31:0]      rdata_lane;

   assign accept = (state == IDLE) & mem_valid &
                   d_cache_access & ~flush;

   assign hit_timeout = (state == REQ) & ~cache_ready &
                        (cnt == CNT_LAST);

   // Byte lane picked by the latched address, sign-extended for LDB.
   always_comb begin
      rbyte = cache_rdata[7:0];
      unique case (cache_addr[1:0])
         2'd0: rbyte = cache_rdata[7:0];
         2'd1: rbyte = cache_rdata[15:8];
         2'd2: rbyte = cache_rdata[23:16];
         2'd3: rbyte = cache_rdata[31:24];
         default: rbyte = cache_rdata[7:0];
      endcase
      rdata_lane = cache_byte ? {{24{rbyte[7]}}, rbyte}
                              : cache_rdata;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: DONE is a single cycle, timeout falls back to IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = REQ;
         REQ: begin
            if (cache_ready)      state_nxt = DONE;
            else if (hit_timeout) state_nxt = IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pipeline stall and the load completion pulse.
   always_comb begin
      stall      = accept | (state == REQ);
      load_valid = (state == DONE) & cache_op & ~discard;
   end

   // Request registers, timeout counter, load capture and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_req   <= 1'b0;
         cache_op    <= 1'b0;
         cache_byte  <= 1'b0;
         cache_addr  <= '0;
         cache_wdata <= '0;
         load_data   <= '0;
         timeout_err <= 1'b0;
         cnt         <= '0;
         discard     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  cache_req   <= 1'b1;
                  cache_op    <= d_cache_op;
                  cache_byte  <= is_byte_op;
                  cache_addr  <= addr;
                  cache_wdata <= is_byte_op ? {4{store_data[7:0]}}
                                            : store_data;
                  cnt         <= '0;
                  discard     <= 1'b0;
               end
            end
            REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (flush) discard <= 1'b1;
               if (cache_ready) begin
                  cache_req <= 1'b0;
                  if (cache_op) load_data <= rdata_lane;
               end else if (hit_timeout) begin
                  cache_req   <= 1'b0;
                  timeout_err <= 1'b1;
                  discard     <= 1'b0;
               end
            end
            DONE:    discard <= 1'b0;
            default: discard <= 1'b0;
         endcase
      end
   end

endmodule
